task_dispatcher: RTL

//  Central scheduler for the hardware task slots. Each cycle it sees every slot's {id,priority} word,

---
 rtl/task_dispatcher_pkg.sv | 45 ++++
 rtl/task_dispatcher_prio_argmax.sv | 36 +++
 rtl/task_dispatcher.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the task dispatcher: opcode encodings, FSM states and
// the opcode bus payload.
package task_dispatcher_pkg;

  localparam int unsigned TASK_WORD_W = 8;
  localparam int unsigned OP_W        = 16;

  typedef enum logic [3:0] {
    OP_READY   = 4'h1,
    OP_SUSPEND = 4'h2,
    OP_WAIT    = 4'h3,
    OP_KILL    = 4'h4,
    OP_PRIO    = 4'h5,
    OP_HIT     = 4'h6,
    OP_EXEC    = 4'h7,
    OP_FINISH  = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST,
    ST_SELECT,
    ST_ISSUE,
    ST_ACK,
    ST_RUN,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] id;
    logic [3:0] op;
    logic [3:0] arg;
  } opcode_t;

  function automatic opcode_t make_op(input logic [3:0] id, input op_e op);
    opcode_t o;
    o.rsvd = 4'h0;
    o.id   = id;
    o.op   = op;
    o.arg  = 4'h0;
    return o;
  endfunction

endpackage

// File: rtl/task_dispatcher_prio_argmax.sv
// Combinational highest-priority picker over all slot words; equal priorities
// resolve to the lowest slot index. A zero word marks a slot as not ready.
module task_dispatcher_prio_argmax
  import task_dispatcher_pkg::*;
#(
  parameter int unsigned N_TASKS = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [TASK_WORD_W*N_TASKS-1:0] task_word_i,
  output logic                           any_ready_o,
  output logic [IDX_W-1:0]               win_idx_o,
  output logic [3:0]                     win_id_o
);

  logic [TASK_WORD_W-1:0] word;
  logic [3:0]             best_prio;

  always_comb begin
    any_ready_o = 1'b0;
    win_idx_o   = '0;
    win_id_o    = 4'h0;
    best_prio   = 4'h0;
    word        = '0;
    for (int i = 0; i < int'(N_TASKS); i++) begin
      word = task_word_i[i*TASK_WORD_W +: TASK_WORD_W];
      // strict compare keeps the earliest slot on a tie
      if (word != '0 && (!any_ready_o || word[3:0] > best_prio)) begin
        any_ready_o = 1'b1;
        best_prio   = word[3:0];
        win_idx_o   = IDX_W'(i);
        win_id_o    = word[7:4];
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Task scheduler: dispatches the highest-priority ready slot onto the opcode bus,
// holds it for a quantum, issues Finish, and forwards host opcodes between dispatches.
module task_dispatcher
  import task_dispatcher_pkg::*;
#(
  parameter int unsigned N_TASKS     = 8,
  parameter int unsigned QUANTUM     = 1000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [TASK_WORD_W*N_TASKS-1:0] task_word_i,
  input  logic [N_TASKS-1:0]             exe_flag_i,
  input  logic                           host_valid_i,
  input  logic [OP_W-1:0]                host_op_i,
  output logic                           host_ready_o,
  output logic [OP_W-1:0]                op_out_o,
  output logic                           op_strobe_o,
  output logic [3:0]                     cur_id_o,
  output logic                           busy_o,
  output logic                           fault_o,
  output logic [7:0]                     fault_cnt_o
);

  localparam int unsigned IDX_W = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned QNT_W = $clog2(QUANTUM + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [QNT_W-1:0] qnt_cnt_q, qnt_cnt_d;
  logic [OP_W-1:0]  op_out_q, op_out_d;
  logic             op_strobe_q, op_strobe_d;
  logic             host_ready_q, host_ready_d;
  logic [3:0]       cur_id_q, cur_id_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [7:0]       fault_cnt_q, fault_cnt_d;

  logic             any_ready_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [3:0]       win_id_c;
  logic             ack_seen_c;

  task_dispatcher_prio_argmax #(
    .N_TASKS (N_TASKS),
    .IDX_W   (IDX_W)
  ) u_argmax (
    .task_word_i (task_word_i),
    .any_ready_o (any_ready_c),
    .win_idx_o   (win_idx_c),
    .win_id_o    (win_id_c)
  );

  assign ack_seen_c = exe_flag_i[winner_q];

  // Next-state and registered-output computation; strobes are set on the edge
  // entering HOST/ISSUE/FINISH so they are visible during that state.
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    ack_cnt_d    = ack_cnt_q;
    qnt_cnt_d    = qnt_cnt_q;
    op_out_d     = op_out_q;
    op_strobe_d  = 1'b0;
    host_ready_d = 1'b0;
    cur_id_d     = cur_id_q;
    busy_d       = busy_q;
    fault_d      = fault_q;
    fault_cnt_d  = fault_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (host_valid_i) begin
          state_d      = ST_HOST;
          op_out_d     = host_op_i;
          op_strobe_d  = 1'b1;
          host_ready_d = 1'b1;
        end else if (en_i && any_ready_c) begin
          state_d = ST_SELECT;
        end
      end
      ST_HOST: state_d = ST_IDLE;
      ST_SELECT: begin
        if (any_ready_c) begin
          state_d     = ST_ISSUE;
          winner_d    = win_idx_c;
          op_out_d    = make_op(win_id_c, OP_EXEC);
          op_strobe_d = 1'b1;
          cur_id_d    = win_id_c;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_ACK;
        ack_cnt_d = '0;
      end
      ST_ACK: begin
        if (ack_seen_c) begin
          state_d   = ST_RUN;
          qnt_cnt_d = '0;
        end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
          state_d     = ST_IDLE;
          fault_d     = 1'b1;
          fault_cnt_d = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;
          cur_id_d    = 4'h0;
          busy_d      = 1'b0;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_RUN: begin
        if (!ack_seen_c || qnt_cnt_q == QNT_W'(QUANTUM - 1)) begin
          state_d     = ST_FINISH;
          op_out_d    = make_op(cur_id_q, OP_FINISH);
          op_strobe_d = 1'b1;
        end else begin
          qnt_cnt_d = qnt_cnt_q + QNT_W'(1);
        end
      end
      ST_FINISH: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        cur_id_d = 4'h0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      winner_q     <= '0;
      ack_cnt_q    <= '0;
      qnt_cnt_q    <= '0;
      op_out_q     <= '0;
      op_strobe_q  <= 1'b0;
      host_ready_q <= 1'b0;
      cur_id_q     <= 4'h0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_cnt_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      ack_cnt_q    <= ack_cnt_d;
      qnt_cnt_q    <= qnt_cnt_d;
      op_out_q     <= op_out_d;
      op_strobe_q  <= op_strobe_d;
      host_ready_q <= host_ready_d;
      cur_id_q     <= cur_id_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
      fault_cnt_q  <= fault_cnt_d;
    end
  end

  assign op_out_o     = op_out_q;
  assign op_strobe_o  = op_strobe_q;
  assign host_ready_o = host_ready_q;
  assign cur_id_o     = cur_id_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;
  assign fault_cnt_o  = fault_cnt_q;

endmodule
